// File: rtl/lfsr_rand_gen_if.sv
// Request/response bus between a random-value client and lfsr_rand_gen.
interface lfsr_rand_gen_if #(
    parameter int unsigned OUT_WIDTH = 8
);
    logic                 i_req;
    logic [OUT_WIDTH-1:0] i_range;
    logic                 o_ready;
    logic                 o_valid;
    logic [OUT_WIDTH-1:0] o_value;

    // Client side: issues requests, consumes results.
    modport master (
        output i_req,
        output i_range,
        input  o_ready,
        input  o_valid,
        input  o_value
    );

    // Generator side.
    modport slave (
        input  i_req,
        input  i_range,
        output o_ready,
        output o_valid,
        output o_value
    );
endinterface

// File: rtl/lfsr_rand_gen.sv
// Galois LFSR random generator with seed loading, lock-up recovery and a
// ranged-value request port served by bounded rejection sampling.
module lfsr_rand_gen #(
    parameter int unsigned       WIDTH     = 16,
    parameter logic [WIDTH-1:0]  TAPS      = WIDTH'(16'hB400),
    parameter logic [WIDTH-1:0]  SEED      = WIDTH'(16'h0001),
    parameter int unsigned       OUT_WIDTH = 8,
    parameter int unsigned       MAX_TRIES = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_seed_load,
    input  logic [WIDTH-1:0] i_seed,
    output logic [WIDTH-1:0] o_state,
    output logic             o_lockup,
    lfsr_rand_gen_if.slave   bus
);

    localparam int unsigned TRIES_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } fsm_t;

    fsm_t                 fsm_q, fsm_d;
    logic [WIDTH-1:0]     state_q, state_d;
    logic                 lockup_q, lockup_d;
    logic [OUT_WIDTH-1:0] range_q, range_d;
    logic [OUT_WIDTH-1:0] mask_q, mask_d;
    logic [TRIES_W-1:0]   tries_q, tries_d;
    logic [OUT_WIDTH-1:0] value_q, value_d;
    logic                 valid_q, valid_d;
    logic                 ready_q, ready_d;
    logic                 lfsr_step;
    logic [OUT_WIDTH-1:0] cand;

    // Smallest 2^k - 1 covering range-1; a zero range means the full width.
    function automatic logic [OUT_WIDTH-1:0] range_mask(input logic [OUT_WIDTH-1:0] r);
        logic [OUT_WIDTH-1:0] m;
        if (r == '0) begin
            m = '1;
        end else begin
            m = r - OUT_WIDTH'(1);
            for (int i = 0; i < int'(OUT_WIDTH); i++) begin
                m = m | (m >> 1);
            end
        end
        return m;
    endfunction

    // LFSR next state: seed load, then zero-state recovery, then step.
    always_comb begin
        state_d   = state_q;
        lockup_d  = 1'b0;
        lfsr_step = i_enable || (fsm_q == ST_SEARCH);
        if (i_seed_load) begin
            if (i_seed != '0) begin
                state_d = i_seed;
            end else begin
                state_d  = SEED;
                lockup_d = 1'b1;
            end
        end else if (state_q == '0) begin
            state_d  = SEED;
            lockup_d = 1'b1;
        end else if (lfsr_step) begin
            state_d = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
        end
    end

    // Request FSM: capture range in IDLE, sample candidates in SEARCH.
    always_comb begin
        fsm_d   = fsm_q;
        range_d = range_q;
        mask_d  = mask_q;
        tries_d = tries_q;
        value_d = value_q;
        valid_d = 1'b0;
        cand    = state_q[OUT_WIDTH-1:0] & mask_q;
        case (fsm_q)
            ST_IDLE: begin
                if (bus.i_req) begin
                    range_d = bus.i_range;
                    mask_d  = range_mask(bus.i_range);
                    tries_d = '0;
                    fsm_d   = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if ((range_q == '0) || (cand < range_q)) begin
                    value_d = cand;
                    valid_d = 1'b1;
                    fsm_d   = ST_IDLE;
                end else if (tries_q == TRIES_W'(MAX_TRIES - 1)) begin
                    // mask < 2*range, so one subtraction lands in range
                    value_d = cand - range_q;
                    valid_d = 1'b1;
                    fsm_d   = ST_IDLE;
                end else begin
                    tries_d = tries_q + TRIES_W'(1);
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
        ready_d = (fsm_d == ST_IDLE);
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            fsm_q    <= ST_IDLE;
            state_q  <= SEED;
            lockup_q <= 1'b0;
            range_q  <= '0;
            mask_q   <= '0;
            tries_q  <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            lockup_q <= lockup_d;
            range_q  <= range_d;
            mask_q   <= mask_d;
            tries_q  <= tries_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    assign o_state     = state_q;
    assign o_lockup    = lockup_q;
    assign bus.o_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.o_value = value_q;

endmodule
